// File: rtl/out_port_bcd_seg.sv
// ---------------------------------------------------------------------------
// out_port_bcd_seg
//
// Sequential binary-to-BCD converter and two-digit 7-segment driver for one
// 32-bit CPU output port. Whenever the port value changes, the low IN_W bits
// are converted with an iterative double-dabble FSM (one step per clock).
// The result is latched onto an active-low HEX digit pair. The displayed
// digits hold steady between conversions.
//
// Parameters:
//   IN_W      number of low port bits converted (7..16); any set bit in
//             out_port[31:IN_W] makes the value an overflow
//   BLANK_LZ  1: a tens digit of 0 is shown blank
//
// Ports:
//   clk       system clock, rising-edge
//   reset     asynchronous, active-low reset
//   out_port  32-bit unsigned value from the CPU output port
//   HEX1      tens digit, active-low {g,f,e,d,c,b,a}
//   HEX0      ones digit, active-low {g,f,e,d,c,b,a}
//   busy      high while a conversion is in progress
//   ovf       high while the display shows the overflow pattern (dashes)
// ---------------------------------------------------------------------------
module out_port_bcd_seg #(
    parameter int IN_W     = 8,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] out_port,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0,
    output logic        busy,
    output logic        ovf
);

    // Shift register: 12-bit BCD field (hundreds/tens/ones) above the binary.
    localparam int SW = IN_W + 12;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] HEX1_RST  = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
    localparam logic [4:0] LAST_STEP = 5'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t        state;
    logic [31:0]   last_val;
    logic [SW-1:0] sr;
    logic [4:0]    cnt;
    logic          lost;

    logic [SW-1:0] adj;
    logic [SW-1:0] sr_next;
    logic [3:0]    ones;
    logic [3:0]    tens;
    logic [3:0]    hunds;
    logic          hi_nz;
    logic          too_big;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        adj = sr;
        for (int unsigned k = 0; k < 3; k++) begin
            if (sr[IN_W + 4*k +: 4] >= 4'd5) begin
                adj[IN_W + 4*k +: 4] = sr[IN_W + 4*k +: 4] + 4'd3;
            end
        end
    end

    assign sr_next = {adj[SW-2:0], 1'b0};

    assign ones    = sr[IN_W     +: 4];
    assign tens    = sr[IN_W + 4 +: 4];
    assign hunds   = sr[IN_W + 8 +: 4];
    assign hi_nz   = |(last_val >> IN_W);
    // A bit falling off the top of the BCD field means the value is >= 1000,
    // which would otherwise wrap and leave the hundreds nibble looking clean.
    assign too_big = hi_nz || (hunds != 4'd0) || lost;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_val <= '0;
            sr       <= '0;
            cnt      <= '0;
            lost     <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            HEX1     <= HEX1_RST;
            HEX0     <= SEG_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (out_port != last_val) begin
                        last_val <= out_port;
                        sr       <= {12'b0, out_port[IN_W-1:0]};
                        cnt      <= '0;
                        lost     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr   <= sr_next;
                    lost <= lost | adj[SW-1];
                    cnt  <= cnt + 5'd1;
                    if (cnt == LAST_STEP) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (too_big) begin
                        HEX1 <= SEG_DASH;
                        HEX0 <= SEG_DASH;
                        ovf  <= 1'b1;
                    end else begin
                        HEX1 <= (BLANK_LZ && tens == 4'd0) ? SEG_BLANK : enc(tens);
                        HEX0 <= enc(ones);
                        ovf  <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_bcd_seg.sv
// ---------------------------------------------------------------------------
// tb_out_port_bcd_seg
//
// Directed bench for out_port_bcd_seg. Two instances share the stimulus:
// u0 with BLANK_LZ=0 and u1 with BLANK_LZ=1. Each driven value pushes its
// expected display onto a scoreboard queue. The entry is popped and compared
// when busy falls.
// ---------------------------------------------------------------------------
module tb_out_port_bcd_seg;

    localparam int IN_W = 8;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] out_port;
    logic [6:0]  hex1_a, hex0_a, hex1_b, hex0_b;
    logic        busy_a, busy_b, ovf_a, ovf_b;

    out_port_bcd_seg #(.IN_W(IN_W), .BLANK_LZ(1'b0)) u0 (
        .clk(clk), .reset(reset), .out_port(out_port),
        .HEX1(hex1_a), .HEX0(hex0_a), .busy(busy_a), .ovf(ovf_a)
    );

    out_port_bcd_seg #(.IN_W(IN_W), .BLANK_LZ(1'b1)) u1 (
        .clk(clk), .reset(reset), .out_port(out_port),
        .HEX1(hex1_b), .HEX0(hex0_b), .busy(busy_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] h1;
        logic [6:0] h0;
        logic [6:0] h1b;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] seg [10];
    int         passed = 0;
    int         total  = 0;
    int         t_ref  = 0;

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        int   t, o;
        if (v > 32'd99) begin
            e.h1 = DASH; e.h0 = DASH; e.h1b = DASH; e.ovf = 1'b1;
        end else begin
            t = int'(v) / 10;
            o = int'(v) % 10;
            e.h1  = seg[t];
            e.h0  = seg[o];
            e.h1b = (t == 0) ? BLANK : seg[t];
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] v);
        @(negedge clk);
        out_port = v;
        t_ref    = cyc;
        sb.push_back(model(v));
    endtask

    // Waits for busy to rise and fall; returns edges since t_ref and the
    // number of negedge samples with busy high.
    task automatic wait_done(output int lat, output int bcnt);
        bit seen = 1'b0;
        bit done = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (busy_a) begin
                seen = 1'b1;
                bcnt++;
            end else if (seen) begin
                lat  = cyc - t_ref;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            $error("FAIL timeout: busy did not complete, observed busy=%0b expected a falling edge", busy_a);
        end
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s: scoreboard empty, observed no entry expected one", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".hex1"},  32'(hex1_a), 32'(e.h1));
            chk({tag, ".hex0"},  32'(hex0_a), 32'(e.h0));
            chk({tag, ".ovf"},   32'(ovf_a),  32'(e.ovf));
            chk({tag, ".hex1b"}, 32'(hex1_b), 32'(e.h1b));
            chk({tag, ".hex0b"}, 32'(hex0_b), 32'(e.h0));
            chk({tag, ".ovfb"},  32'(ovf_b),  32'(e.ovf));
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] v);
        int lat, bcnt;
        drive(v);
        wait_done(lat, bcnt);
        chk({tag, ".lat"},  32'(lat),  32'(IN_W + 2));
        chk({tag, ".busy"}, 32'(bcnt), 32'(IN_W + 1));
        compare_front(tag);
    endtask

    task automatic idle_check(input string tag, input int n);
        int bcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy_a || busy_b) bcnt++;
        end
        chk({tag, ".nobusy"}, 32'(bcnt), 32'd0);
    endtask

    initial begin
        int lat, bcnt;
        seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        // Reset with a zero port value
        reset    = 1'b0;
        out_port = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.hex1",  32'(hex1_a), 32'h40);
        chk("rst.hex0",  32'(hex0_a), 32'h40);
        chk("rst.hex1b", 32'(hex1_b), 32'(BLANK));
        chk("rst.busy",  32'(busy_a), 32'd0);
        chk("rst.ovf",   32'(ovf_a),  32'd0);
        reset = 1'b1;
        idle_check("zero", 12);
        chk("zero.hex0", 32'(hex0_a), 32'h40);

        // Basic conversions and the 99/100 boundary
        convert("v37", 32'd37);
        idle_check("const37", 12);
        convert("v99", 32'd99);
        convert("v100", 32'd100);
        convert("v0x105", 32'h0000_0105);
        convert("v5", 32'd5);
        convert("v0", 32'd0);
        convert("v255", 32'd255);
        convert("vffff", 32'hFFFF_FFFF);
        convert("v10", 32'd10);

        // Change during SHIFT: 37 completes first, then 62 follows
        drive(32'd37);
        repeat (3) @(negedge clk);
        out_port = 32'd62;
        sb.push_back(model(32'd62));
        wait_done(lat, bcnt);
        chk("chg.lat37", 32'(lat), 32'(IN_W + 2));
        compare_front("chg37");
        wait_done(lat, bcnt);
        chk("chg.lat62",  32'(lat),  32'(2 * (IN_W + 2)));
        chk("chg.busy62", 32'(bcnt), 32'(IN_W + 1));
        compare_front("chg62");

        // Reset asserted mid-SHIFT, then restart with the held value
        drive(32'd200);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst.hex1",  32'(hex1_a), 32'h40);
        chk("midrst.hex0",  32'(hex0_a), 32'h40);
        chk("midrst.hex1b", 32'(hex1_b), 32'(BLANK));
        chk("midrst.busy",  32'(busy_a), 32'd0);
        chk("midrst.ovf",   32'(ovf_a),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        t_ref = cyc;
        wait_done(lat, bcnt);
        chk("restart.lat", 32'(lat), 32'(IN_W + 2));
        compare_front("restart200");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
